// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit unsigned adder with carry-in, split into STAGES ripple chunks of
//   WIDTH/STAGES bits. Each stage resolves one chunk and registers it, so one
//   carry segment settles per cycle. Unconsumed operand bits and completed sum
//   bits travel down the pipe with the transaction; the last stage presents a
//   fully aligned result. Valid/ready handshakes on both sides with full
//   backpressure through a combinational ready chain.
//
// Parameters
//   WIDTH   operand / sum width (default 16)
//   STAGES  pipeline depth = latency in cycles (default 4); WIDTH % STAGES == 0
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      asynchronous reset, active-high
//   i_valid    operand transfer request
//   o_ready    block can accept operands this cycle
//   i_x, i_y   operands (WIDTH)
//   i_carry    carry-in
//   o_valid    result available
//   i_ready    downstream accepts result this cycle
//   o_sum      x + y + carry, low WIDTH bits
//   o_carry    carry-out of bit WIDTH-1
//   o_overflow signed overflow of the result (only with PIPELINED_ADDER_OVF_EN)
//
// Optional feature macro: PIPELINED_ADDER_OVF_EN adds the o_overflow output.
// -----------------------------------------------------------------------------
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
`ifdef PIPELINED_ADDER_OVF_EN
  output logic             o_carry,
  output logic             o_overflow
`else
  output logic             o_carry
`endif
);

  localparam int C    = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Stage registers
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  x_q   [STAGES];
  logic [WIDTH-1:0]  y_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic              carry_q [STAGES];

  // What each stage would load: from the ports for stage 0, else stage k-1
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_x   [STAGES];
  logic [WIDTH-1:0]  src_y   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic              src_c   [STAGES];
  logic [WIDTH-1:0]  nxt_sum [STAGES];
  logic              nxt_c   [STAGES];

  // ready[k] means stage k may load this cycle; ready[STAGES] is downstream
  logic [STAGES:0] ready;
  assign ready[STAGES] = i_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [C:0]       chunk;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_src_in
      assign src_v[k]   = i_valid;
      assign src_x[k]   = i_x;
      assign src_y[k]   = i_y;
      assign src_c[k]   = i_carry;
      assign src_sum[k] = '0;
    end else begin : g_src_prev
      assign src_v[k]   = valid_q[k-1];
      assign src_x[k]   = x_q[k-1];
      assign src_y[k]   = y_q[k-1];
      assign src_c[k]   = carry_q[k-1];
      assign src_sum[k] = sum_q[k-1];
    end

    assign chunk = {1'b0, src_x[k][k*C +: C]}
                 + {1'b0, src_y[k][k*C +: C]}
                 + {{C{1'b0}}, src_c[k]};

    // NOTE: give every always_comb variable a full default first so a
    // partial update (here one chunk) can never infer a latch.
    always_comb begin
      merged             = src_sum[k];
      merged[k*C +: C]   = chunk[C-1:0];
    end

    assign nxt_sum[k] = merged;
    assign nxt_c[k]   = chunk[C];
    assign ready[k]   = !valid_q[k] || ready[k+1];
  end

  // NOTE: all pipeline state, arrays included, is reset here because the
  // result must read as zero after reset; state uses non-blocking (<=)
  // assignments so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k]     <= '0;
        y_q[k]     <= '0;
        sum_q[k]   <= '0;
        carry_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= src_v[k];
          // Data only moves with a real transaction, so the output holds
          // its last value while no result is valid.
          if (src_v[k]) begin
            x_q[k]     <= src_x[k];
            y_q[k]     <= src_y[k];
            sum_q[k]   <= nxt_sum[k];
            carry_q[k] <= nxt_c[k];
          end
        end
      end
    end
  end

`ifdef PIPELINED_ADDER_OVF_EN
  // Carry into the MSB is x^y^sum at that bit; overflow is that XOR carry-out.
  logic ovf_q;
  logic ovf_nxt;
  assign ovf_nxt = src_x[LAST][WIDTH-1] ^ src_y[LAST][WIDTH-1]
                 ^ nxt_sum[LAST][WIDTH-1] ^ nxt_c[LAST];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
    end else if (ready[LAST] && src_v[LAST]) begin
      ovf_q <= ovf_nxt;
    end
  end

  assign o_overflow = ovf_q;
`endif

  assign o_ready = ready[0];
  assign o_valid = valid_q[LAST];
  assign o_sum   = sum_q[LAST];
  assign o_carry = carry_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//   Directed bench for pipelined_adder (WIDTH=16, STAGES=4). Inputs change 1ns
//   after the rising edge; a negedge monitor records every handshake that will
//   occur at the next rising edge: input transfers push the reference sum onto
//   a queue, output transfers pop and compare.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_x;
  logic [WIDTH-1:0] i_y;
  logic             i_carry;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             o_overflow;
`endif

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_carry   (i_carry),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_sum     (o_sum),
`ifdef PIPELINED_ADDER_OVF_EN
    .o_carry   (o_carry),
    .o_overflow(o_overflow)
`else
    .o_carry   (o_carry)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_in     = 0;
  int n_out    = 0;
  bit rand_ready = 1'b0;

  // {overflow, carry, sum}
  logic [WIDTH+1:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c);
    logic [WIDTH:0] s;
    logic           ovf;
    s   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    ovf = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
`ifdef PIPELINED_ADDER_OVF_EN
    return {ovf, s};
`else
    return {1'b0, s};
`endif
  endfunction

  function automatic logic [WIDTH+1:0] observed();
`ifdef PIPELINED_ADDER_OVF_EN
    return {o_overflow, o_carry, o_sum};
`else
    return {1'b0, o_carry, o_sum};
`endif
  endfunction

  // Scoreboard monitor
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (i_valid && o_ready) begin
        sb.push_back(model(i_x, i_y, i_carry));
        n_in++;
      end
      if (o_valid && i_ready) begin
        n_out++;
        check("out_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("result", 32'(observed()), 32'(sb.pop_front()));
      end
    end
  end

  always @(posedge i_rst) sb.delete();

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Drive one operand set and hold it until accepted (bounded).
  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
    bit acc;
    int budget;
    i_valid = 1'b1;
    i_x = x;
    i_y = y;
    i_carry = c;
    budget = 200;
    do begin
      if (rand_ready) i_ready = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      acc = o_ready;
      step();
      budget--;
    end while (!acc && budget > 0);
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_x = '0;
    i_y = '0;
    i_carry = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 200;
    while (sb.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    check(tag, sb.size(), 0);
  endtask

  int base;

  initial begin
    i_rst   = 1'b1;
    i_ready = 1'b0;
    idle();
    #1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_o_sum",   32'(o_sum),   0);
    check("rst_o_carry", 32'(o_carry), 0);
    check("rst_o_ready", 32'(o_ready), 1);
    i_rst = 1'b0;
    step();

    // Full carry ripple and exact latency
    i_ready = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0);   // accepted at edge N, now N+1ns
    idle();
    step();
    step();                           // after edge N+2
    check("lat_not_early", 32'(o_valid), 0);
    step();                           // after edge N+3
    check("lat_valid", 32'(o_valid), 1);
    check("ripple_sum", {15'd0, o_carry, o_sum}, 32'h0001_0000);
    step();
    check("lat_one_cycle", 32'(o_valid), 0);
    wait_drain("ripple_drain");

    // Streaming all bit0 combinations back to back
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] b;
      b = 3'(i);
      send({15'd0, b[2]}, {15'd0, b[1]}, b[0]);
    end
    idle();
    wait_drain("stream_drain");
    check("stream_count", n_out - base, 8);

    // Backpressure: fill with i_ready low, then drain while still accepting
    i_ready = 1'b0;
    base = n_in;
    i_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_x = 16'(16'h1111 * i + 16'h00F0);
      i_y = 16'(16'h0F0F + i);
      i_carry = 1'(i);
      step();
    end
    check("bp_accepted", n_in - base, STAGES);
    check("bp_o_ready",  32'(o_ready), 0);
    check("bp_o_valid",  32'(o_valid), 1);
    i_ready = 1'b1;
    #1;
    check("bp_pass_ready", 32'(o_ready), 1);
    base = n_in;
    for (int i = 0; i < 3; i++) begin
      i_x = 16'(16'hA000 + i);
      i_y = 16'(16'h7000 - i);
      i_carry = 1'(~i);
      step();
    end
    check("bp_simul_accept", n_in - base, 3);
    idle();
    wait_drain("bp_drain");

    // Randomised stream with random downstream stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom));
    idle();
    rand_ready = 1'b0;
    i_ready = 1'b1;
    wait_drain("rand_drain");

`ifdef PIPELINED_ADDER_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'h0001, 16'h0001, 1'b0);
    idle();
    wait_drain("ovf_drain");
`endif

    // Reset mid-flight: three transactions parked, reset between edges
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(16'(16'h0100 + i), 16'h0010, 1'b1);
    idle();
    repeat (4) step();
    check("mid_o_valid_before", 32'(o_valid), 1);
    #1 i_rst = 1'b1;
    #1;
    check("mid_o_valid_async", 32'(o_valid), 0);
    check("mid_o_sum_async",   32'(o_sum),   0);
    check("mid_o_ready_async", 32'(o_ready), 1);
    #1 i_rst = 1'b0;
    i_ready = 1'b1;
    base = n_out;
    repeat (10) step();
    check("mid_no_output", n_out - base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
